// File: rtl/unidade_adiantamento.sv
// Hazard controller beside the ID/EX register: registers the EX operand-mux selects and
// stalls IF/ID on load-use and busy-multiplier hazards.
module unidade_adiantamento #(
  parameter int LATENCIA_MULT = 4,
  parameter int LARGURA_REG   = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valido_id,
  input  logic [LARGURA_REG-1:0] rs_id,
  input  logic [LARGURA_REG-1:0] rt_id,
  input  logic                   usa_rs_id,
  input  logic                   usa_rt_id,
  input  logic [LARGURA_REG-1:0] dest_id,
  input  logic                   escreve_id,
  input  logic                   load_id,
  input  logic                   mult_id,
  input  logic                   usa_hilo_id,
  input  logic                   pausa_mem,
  output logic [1:0]             sel_a,
  output logic [1:0]             sel_b,
  output logic                   parar,
  output logic                   bolha
);

  localparam int LARGURA_CONT = $clog2(LATENCIA_MULT + 1);

  typedef enum logic [1:0] {
    SEL_REGFILE = 2'b00,
    SEL_WB      = 2'b01,
    SEL_ALU     = 2'b10
  } sel_t;

  typedef struct packed {
    logic [LARGURA_REG-1:0] dest;
    logic                   escreve;
    logic                   load;
  } estagio_ex_t;

  // The WB stage never forwards (write-before-read register file), and the MEM stage forwards
  // loads and ALU results alike, so only EX needs the load flag.
  estagio_ex_t             est_ex;
  logic [LARGURA_REG-1:0]  mem_dest;
  logic                    mem_escreve;
  logic [LARGURA_CONT-1:0] ocupado;

  logic conflito_load;
  logic conflito_hilo;
  logic entra_ex;
  sel_t sel_a_prox;
  sel_t sel_b_prox;

  function automatic sel_t calc_sel(input logic [LARGURA_REG-1:0] x, input logic usa,
                                    input estagio_ex_t ex, input logic [LARGURA_REG-1:0] m_dest,
                                    input logic m_escreve);
    // NOTE: default assigned first so every path drives the result; no latch is inferred.
    calc_sel = SEL_REGFILE;
    if (usa && (x != '0)) begin
      if (ex.escreve && (ex.dest == x) && !ex.load) calc_sel = SEL_ALU;
      else if (m_escreve && (m_dest == x))          calc_sel = SEL_WB;
    end
  endfunction

  assign conflito_load = est_ex.load && est_ex.escreve && (est_ex.dest != '0) &&
                         ((usa_rs_id && (rs_id == est_ex.dest)) ||
                          (usa_rt_id && (rt_id == est_ex.dest)));
  assign conflito_hilo = (ocupado != '0) && valido_id && (usa_hilo_id || mult_id);

  assign parar    = (conflito_load | conflito_hilo) & ~pausa_mem;
  assign bolha    = parar;
  assign entra_ex = valido_id & ~parar;

  assign sel_a_prox = calc_sel(rs_id, usa_rs_id, est_ex, mem_dest, mem_escreve);
  assign sel_b_prox = calc_sel(rt_id, usa_rt_id, est_ex, mem_dest, mem_escreve);

  // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      est_ex      <= '0;
      mem_dest    <= '0;
      mem_escreve <= 1'b0;
      sel_a       <= SEL_REGFILE;
      sel_b       <= SEL_REGFILE;
    end else if (!pausa_mem) begin
      mem_dest    <= est_ex.dest;
      mem_escreve <= est_ex.escreve;
      if (entra_ex) begin
        est_ex <= '{dest: dest_id, escreve: escreve_id, load: load_id};
        sel_a  <= sel_a_prox;
        sel_b  <= sel_b_prox;
      end else begin
        est_ex <= '0;
        sel_a  <= SEL_REGFILE;
        sel_b  <= SEL_REGFILE;
      end
    end
  end

  // The multiplier keeps running while memory stalls, so the countdown ignores pausa_mem.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ocupado <= '0;
    end else if (!pausa_mem && entra_ex && mult_id) begin
      ocupado <= LARGURA_CONT'(LATENCIA_MULT);
    end else if (ocupado != '0) begin
      ocupado <= ocupado - LARGURA_CONT'(1);
    end
  end

endmodule

// File: tb/tb_unidade_adiantamento.sv
// Directed bench for unidade_adiantamento: expected selects/stall per cycle go through a
// scoreboard queue and are compared after each clock edge.
module tb_unidade_adiantamento;

  logic       clock = 1'b0;
  logic       reset;
  logic       valido_id;
  logic [4:0] rs_id, rt_id, dest_id;
  logic       usa_rs_id, usa_rt_id, escreve_id, load_id, mult_id, usa_hilo_id;
  logic       pausa_mem;
  logic [1:0] sel_a, sel_b;
  logic       parar, bolha;

  int comparados = 0;
  int falhas     = 0;

  typedef struct {
    string      tag;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       parar;
  } esp_t;

  esp_t fila[$];
  logic parar_obs, bolha_obs;

  unidade_adiantamento #(.LATENCIA_MULT(4), .LARGURA_REG(5)) dut (
    .clock(clock), .reset(reset), .valido_id(valido_id), .rs_id(rs_id), .rt_id(rt_id),
    .usa_rs_id(usa_rs_id), .usa_rt_id(usa_rt_id), .dest_id(dest_id), .escreve_id(escreve_id),
    .load_id(load_id), .mult_id(mult_id), .usa_hilo_id(usa_hilo_id), .pausa_mem(pausa_mem),
    .sel_a(sel_a), .sel_b(sel_b), .parar(parar), .bolha(bolha)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] esp);
    comparados++;
    assert (obs === esp) else begin
      falhas++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, esp);
    end
  endtask

  task automatic instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] d,
                       input logic esc, input logic ld, input logic mu, input logic hi);
    valido_id = v; rs_id = rs; rt_id = rt; usa_rs_id = urs; usa_rt_id = urt;
    dest_id = d; escreve_id = esc; load_id = ld; mult_id = mu; usa_hilo_id = hi;
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] d);
    instr(1'b1, rs, rt, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] rt_lixo, input logic [4:0] d);
    instr(1'b1, rs, rt_lixo, 1'b1, 1'b0, d, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop();
    instr(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mult(input logic [4:0] rs, input logic [4:0] rt);
    instr(1'b1, rs, rt, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic mfhi(input logic [4:0] d);
    instr(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Called at a falling edge with ID inputs already driven; parar/bolha are sampled just
  // before the rising edge, the registered selects 1 time unit after it.
  task automatic ciclo(input string tag, input logic p, input logic [1:0] a, input logic [1:0] b);
    esp_t e;
    e.tag = tag; e.parar = p; e.sel_a = a; e.sel_b = b;
    fila.push_back(e);
    #4;
    parar_obs = parar;
    bolha_obs = bolha;
    @(posedge clock);
    #1;
    e = fila.pop_front();
    check({e.tag, ".parar"}, {1'b0, parar_obs}, {1'b0, e.parar});
    check({e.tag, ".bolha"}, {1'b0, bolha_obs}, {1'b0, e.parar});
    check({e.tag, ".sel_a"}, sel_a, e.sel_a);
    check({e.tag, ".sel_b"}, sel_b, e.sel_b);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    pausa_mem = 1'b0;
    nop();
    #1;
    check("reset.sel_a", sel_a, 2'b00);
    check("reset.sel_b", sel_b, 2'b00);
    check("reset.parar", {1'b0, parar}, 2'b00);
    check("reset.bolha", {1'b0, bolha}, 2'b00);
    @(negedge clock);
    reset = 1'b0;

    // add r3,r1,r2 ; sub r4,r3,r5
    alu(5'd1, 5'd2, 5'd3);   ciclo("add_r3",     1'b0, 2'b00, 2'b00);
    alu(5'd3, 5'd5, 5'd4);   ciclo("sub_ex_fwd", 1'b0, 2'b10, 2'b00);
    // add r3 ; nop ; or r6,r7,r3
    alu(5'd1, 5'd2, 5'd3);   ciclo("add_r3_b",   1'b0, 2'b00, 2'b00);
    nop();                   ciclo("nop",        1'b0, 2'b00, 2'b00);
    alu(5'd7, 5'd3, 5'd6);   ciclo("or_mem_fwd", 1'b0, 2'b00, 2'b01);
    // add r3 ; add r3 ; use r3 -> youngest (EX) wins
    alu(5'd1, 5'd2, 5'd3);   ciclo("add_r3_1",   1'b0, 2'b00, 2'b00);
    alu(5'd4, 5'd5, 5'd3);   ciclo("add_r3_2",   1'b0, 2'b00, 2'b00);
    alu(5'd3, 5'd2, 5'd11);  ciclo("ex_priority", 1'b0, 2'b10, 2'b00);
    // lw r8 (rt=r11 unused while r11 sits in EX) ; add r9,r8,r8
    lw(5'd1, 5'd11, 5'd8);   ciclo("lw_rt_unused", 1'b0, 2'b00, 2'b00);
    alu(5'd8, 5'd8, 5'd9);   ciclo("load_use_stall", 1'b1, 2'b00, 2'b00);
    alu(5'd8, 5'd8, 5'd9);   ciclo("load_use_fwd",   1'b0, 2'b01, 2'b01);
    // r0 destinations never forward and never stall
    instr(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    ciclo("addi_r0", 1'b0, 2'b00, 2'b00);
    alu(5'd0, 5'd0, 5'd12);  ciclo("use_r0",     1'b0, 2'b00, 2'b00);
    lw(5'd2, 5'd0, 5'd0);    ciclo("lw_r0",      1'b0, 2'b00, 2'b00);
    alu(5'd0, 5'd12, 5'd13); ciclo("use_r0_after_lw", 1'b0, 2'b00, 2'b01);
    // mult ; mfhi -> four stall cycles
    mult(5'd1, 5'd2);        ciclo("mult",       1'b0, 2'b00, 2'b00);
    mfhi(5'd14);
    for (int i = 0; i < 4; i++) ciclo($sformatf("mfhi_stall%0d", i), 1'b1, 2'b00, 2'b00);
    ciclo("mfhi_go", 1'b0, 2'b00, 2'b00);
    // mult ; independent add does not stall
    mult(5'd5, 5'd6);        ciclo("mult_2",     1'b0, 2'b00, 2'b00);
    alu(5'd14, 5'd1, 5'd15); ciclo("indep_add",  1'b0, 2'b01, 2'b00);
    // lw r17,0(r15) ; add r18,r17,r17 then reset during the stall
    lw(5'd15, 5'd0, 5'd17);  ciclo("lw_r17",     1'b0, 2'b10, 2'b00);
    alu(5'd17, 5'd17, 5'd18);
    #1;
    check("pre_reset.parar", {1'b0, parar}, 2'b01);
    check("pre_reset.bolha", {1'b0, bolha}, 2'b01);
    #1;
    reset = 1'b1;
    #1;
    check("mid_reset.sel_a", sel_a, 2'b00);
    check("mid_reset.sel_b", sel_b, 2'b00);
    check("mid_reset.parar", {1'b0, parar}, 2'b00);
    check("mid_reset.bolha", {1'b0, bolha}, 2'b00);
    @(negedge clock);
    reset = 1'b0;
    // multiplier countdown was cleared by reset
    mfhi(5'd14);             ciclo("mfhi_after_reset", 1'b0, 2'b00, 2'b00);
    alu(5'd14, 5'd2, 5'd19); ciclo("add_r19",    1'b0, 2'b10, 2'b00);
    // memory pause holds selects and shadow stages for three cycles
    pausa_mem = 1'b1;
    alu(5'd19, 5'd14, 5'd20);
    for (int i = 0; i < 3; i++) ciclo($sformatf("pausa%0d", i), 1'b0, 2'b10, 2'b00);
    pausa_mem = 1'b0;        ciclo("pos_pausa",  1'b0, 2'b10, 2'b01);
    // pause masks a pending load-use stall
    lw(5'd20, 5'd0, 5'd21);  ciclo("lw_r21",     1'b0, 2'b10, 2'b00);
    pausa_mem = 1'b1;
    alu(5'd21, 5'd0, 5'd22); ciclo("pausa_mask", 1'b0, 2'b10, 2'b00);
    pausa_mem = 1'b0;        ciclo("stall_after_pausa", 1'b1, 2'b00, 2'b00);
    ciclo("fwd_after_pausa", 1'b0, 2'b01, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, falhas);
    $finish;
  end

endmodule
